// File: rtl/decoder_pkg.sv
// Shared FSM state type and default parameter values for the row scan decoder.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_e;

   localparam int N_DEF     = 3;
   localparam int ROWS_DEF  = 8;
   localparam int DWELL_DEF = 4;
   localparam int BLANK_DEF = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/decoder_n_to_2n.sv
// Combinational N-to-2**N one-hot decoder; all-zero when ena is low.
module decoder_n_to_2n
   import decoder_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic              ena,
   input  logic [N-1:0]      sel,
   output logic [2**N-1:0]   dec
);

   always_comb begin
      dec = '0;
      if (ena) dec[sel] = 1'b1;
   end

endmodule

// File: rtl/row_scan_decoder.sv
// Row scan driver: steps one-hot row drive with dwell and blank gaps, auto-scan or manual select.
//   state    | meaning
//   ST_IDLE  | disabled, out low, row holds last driven index
//   ST_BLANK | all rows off for BLANK cycles between rows
//   ST_DRIVE | one row driven for DWELL cycles
module row_scan_decoder
   import decoder_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ROWS  = ROWS_DEF,
   parameter int DWELL = DWELL_DEF,
   parameter int BLANK = BLANK_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              scan,
   input  logic [N-1:0]      in,
   output logic [2**N-1:0]   out,
   output logic [N-1:0]      row,
   output logic              frame_start
);

   localparam int            CW         = $clog2(max_int(DWELL, BLANK) + 1);
   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [N-1:0]  ROW_LAST   = N'(ROWS - 1);
   localparam logic [N:0]    ROWS_W     = (N+1)'(ROWS);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N-1:0]      row_q, row_d;
   logic              first_q, first_d;
   logic [2**N-1:0]   out_q, out_d;
   logic              frame_start_q, frame_start_d;
   logic              enter_drive;
   logic              dec_en;
   logic [N-1:0]      next_row;

   always_comb begin
      next_row    = (row_q >= ROW_LAST) ? '0 : row_q + N'(1);
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      first_d     = first_q;
      enter_drive = 1'b0;

      if (!ena) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         first_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               row_d = '0;
               if (BLANK == 0) begin
                  enter_drive = 1'b1;
               end else begin
                  state_d = ST_BLANK;
                  cnt_d   = BLANK_LOAD;
               end
            end
            ST_BLANK: begin
               if (cnt_q == '0) enter_drive = 1'b1;
               else             cnt_d = cnt_q - 1'b1;
            end
            ST_DRIVE: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else if (BLANK == 0) begin
                  enter_drive = 1'b1;
               end else begin
                  state_d = ST_BLANK;
                  cnt_d   = BLANK_LOAD;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Mode and manual select are only sampled here, so mid-dwell changes wait for the next row.
      if (enter_drive) begin
         state_d = ST_DRIVE;
         cnt_d   = DWELL_LOAD;
         first_d = 1'b0;
         if (!scan)        row_d = in;
         else if (first_q) row_d = '0;
         else              row_d = next_row;
      end

      dec_en        = (state_d == ST_DRIVE) && ({1'b0, row_d} < ROWS_W);
      frame_start_d = enter_drive && scan && (row_d == '0);
   end

   decoder_n_to_2n #(.N(N)) u_dec (
      .ena (dec_en),
      .sel (row_d),
      .dec (out_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         row_q         <= '0;
         first_q       <= 1'b1;
         out_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         row_q         <= row_d;
         first_q       <= first_d;
         out_q         <= out_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign out         = out_q;
   assign row         = row_q;
   assign frame_start = frame_start_q;

endmodule
